// File: rtl/dadder_serial.sv
// dadder_serial: digit-serial packed-BCD adder/subtractor.
//   Processes one decimal digit per clock, LSD first, so NUM_DIGITS cycles
//   in CALC plus one DONE cycle per operation.
//
// Ports
//   clk       block clock, rising edge
//   reset     synchronous, active-high reset
//   en        start request, sampled only while ready=1
//   op        00 a+b, 01 a-b, 10 b-a, 11 reserved
//   a, b      packed BCD operands, LSD at bits [3:0]
//   ready     high in IDLE
//   busy      high in CALC and DONE
//   done      one-cycle completion pulse
//   result    packed BCD result, held until the next accept
//   cout      add: decimal carry out; subtract: borrow (1 = negative, ten's complement)
//   op_err    reserved op accepted (valid with done)
//   digit_err non-BCD operand digit (valid with done)
//
// Build option
//   DADDER_SERIAL_DIGIT_CHK_EN  when defined, operands are checked for digits > 9;
//                               a failing operation returns result=0, cout=0,
//                               digit_err=1. Otherwise digit_err is tied low.

module dadder_serial #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_WIDTH = 4 * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cout,
    output logic                  op_err,
    output logic                  digit_err
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    state_t                state_q, state_d;
    logic                  accept;

    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic [1:0]            op_q;
    logic [CW-1:0]         cnt_q;
    logic                  carry_q, cout_q, op_err_q;

    logic                  is_sub;
    logic [DATA_WIDTH-1:0] x_src, y_src;
    logic [3:0]            x_d, y_d, dig;
    logic [4:0]            sum;
    logic                  c_nxt;
    logic                  bad_digit;
    logic                  err;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (en) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit step. Subtraction is nines-complement of the subtrahend with
    // carry-in 1; b-a just swaps the operand roles.
    // ------------------------------------------------------------------
    always_comb begin
        is_sub = (op_q == 2'b01) || (op_q == 2'b10);
        x_src  = (op_q == 2'b10) ? b_q : a_q;
        y_src  = (op_q == 2'b10) ? a_q : b_q;
        x_d    = x_src[{cnt_q, 2'b00} +: 4];
        y_d    = is_sub ? (4'd9 - y_src[{cnt_q, 2'b00} +: 4]) : y_src[{cnt_q, 2'b00} +: 4];
        sum    = {1'b0, x_d} + {1'b0, y_d} + {4'b0000, carry_q};
        if (sum > 5'd9) begin
            dig   = 4'(sum - 5'd10);
            c_nxt = 1'b1;
        end else begin
            dig   = sum[3:0];
            c_nxt = 1'b0;
        end
    end

`ifdef DADDER_SERIAL_DIGIT_CHK_EN
    logic digit_err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || accept)
            digit_err_q <= 1'b0;
        else if (state_q == CALC && cnt_q == LAST)
            digit_err_q <= bad_digit & ~op_err_q;   // op_err wins when both apply
    end

    assign digit_err = digit_err_q;
`else
    assign bad_digit = 1'b0;
    assign digit_err = 1'b0;
`endif

    assign err = op_err_q | bad_digit;

    // ------------------------------------------------------------------
    // Datapath. Result is cleared on accept and only written when no error
    // applies, so error cases finish with result=0 without a final clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            op_err_q <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            cnt_q    <= '0;
            res_q    <= '0;
            carry_q  <= (op == 2'b01) || (op == 2'b10);
            cout_q   <= 1'b0;
            op_err_q <= (op == 2'b11);
        end else if (state_q == CALC) begin
            cnt_q   <= cnt_q + 1'b1;
            carry_q <= c_nxt;
            if (!err) res_q[{cnt_q, 2'b00} +: 4] <= dig;
            if (cnt_q == LAST) cout_q <= err ? 1'b0 : (is_sub ? ~c_nxt : c_nxt);
        end
    end

    assign result = res_q;
    assign cout   = cout_q;
    assign op_err = op_err_q;

endmodule

// File: tb/tb_dadder_serial.sv
// tb_dadder_serial: self-checking bench for dadder_serial (NUM_DIGITS=4).
// Expected values come from an integer decimal reference model.

module tb_dadder_serial;

    localparam int ND = 4;
    localparam int DW = 4 * ND;

`ifdef DADDER_SERIAL_DIGIT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, en;
    logic [1:0]    op;
    logic [DW-1:0] a, b;
    logic          ready, busy, done, cout, op_err, digit_err;
    logic [DW-1:0] result;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    dadder_serial #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .op        (op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .op_err    (op_err),
        .digit_err (digit_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint bcd2int(input logic [DW-1:0] v);
        longint r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [DW-1:0] int2bcd(input longint n);
        logic [DW-1:0] r = '0;
        longint t = n;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_bcd();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: plain integer add/subtract modulo 10^ND.
    task automatic model(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         output logic [DW-1:0] r, output logic c, output logic oe);
        longint m = 1;
        longint ix = bcd2int(x);
        longint iy = bcd2int(y);
        longint d;
        for (int i = 0; i < ND; i++) m = m * 10;
        oe = 1'b0;
        case (o)
            2'b00: begin
                d = ix + iy;
                c = (d >= m);
                r = int2bcd(d % m);
            end
            2'b01, 2'b10: begin
                d = (o == 2'b01) ? ix - iy : iy - ix;
                c = (d < 0);
                r = int2bcd(d < 0 ? d + m : d);
            end
            default: begin
                r  = '0;
                c  = 1'b0;
                oe = 1'b1;
            end
        endcase
    endtask

    // One full operation; optionally scrambles inputs and en while busy.
    task automatic run_op(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [DW-1:0] er, input logic ec, input logic eo,
                          input logic ed, input bit scram);
        int lat;
        bit seen, rdy_busy;
        logic [DW-1:0] held;
        for (int k = 0; k < 20 && !ready; k++) tick();
        check("ready_before_accept", ready, 1);
        op = o; a = x; b = y; en = 1'b1;
        tick();
        en = 1'b0;
        lat = 1; seen = 1'b0; rdy_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (ready) rdy_busy = 1'b1;
            if (scram) begin
                a  = DW'($urandom);
                b  = DW'($urandom);
                op = 2'($urandom);
                en = 1'($urandom);
            end
            tick();
            lat++;
        end
        en = 1'b0;
        check("done_seen", seen, 1);
        check("latency", lat, ND + 1);
        check("ready_low_busy", {rdy_busy, ready, busy}, 3'b001);
        check("result", result, er);
        check("cout", cout, ec);
        check("op_err", op_err, eo);
        check("digit_err", digit_err, ed);
        held = result;
        tick();
        check("done_one_cycle", {done, ready, busy}, 3'b010);
        check("result_held", result, held);
    endtask

    initial begin : main
        logic [DW-1:0] x, y, er;
        logic ec, eo;
        bit sawdone;
        int prev_acc, n_acc, n_done;
        bit prev_ready;

        reset = 1'b1; en = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        check("rst_status", {ready, busy, done}, 3'b100);
        check("rst_result", result, 0);
        check("rst_flags", {cout, op_err, digit_err}, 3'b000);

        // en together with reset must be ignored
        en = 1'b1;
        tick();
        en = 1'b0;
        reset = 1'b0;
        check("rst_en_ignored", {ready, busy}, 2'b10);

        // reset in the middle of CALC aborts with no done pulse
        op = 2'b00; a = rand_bcd(); b = rand_bcd(); en = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick();
        check("mid_calc_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_status", {ready, busy, done}, 3'b100);
        check("abort_regs", {result, cout, op_err}, '0);
        sawdone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) sawdone = 1'b1;
            tick();
        end
        check("abort_no_done", sawdone, 0);

        run_op(2'b00, 16'h1234, 16'h8766, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(2'b01, 16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b01, 16'h0001, 16'h0002, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 16'h0250, 16'h1000, 16'h0750, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(2'b11, rand_bcd(), rand_bcd(), 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b00, 16'h00A0, 16'h0001, CHK ? 16'h0000 : 16'h0101, 1'b0, 1'b0, CHK, 1'b0);
        run_op(2'b11, 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b00, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            logic [1:0] o;
            o = 2'($urandom_range(0, 3));
            x = rand_bcd();
            y = rand_bcd();
            model(o, x, y, er, ec, eo);
            run_op(o, x, y, er, ec, eo, 1'b0, bit'($urandom_range(0, 1)));
        end

        // back-to-back: en held high, accepts every ND+2 cycles
        op = 2'b00; a = 16'h0005; b = 16'h0007; en = 1'b1;
        prev_acc = -1; n_acc = 0; n_done = 0; prev_ready = ready;
        for (int i = 0; i < 52; i++) begin
            if (i == 40) en = 1'b0;
            tick();
            if (prev_ready && busy) begin
                if (prev_acc >= 0) check("b2b_interval", i - prev_acc, ND + 2);
                prev_acc = i;
                n_acc++;
            end
            if (done) begin
                n_done++;
                check("b2b_result", {result, cout}, {16'h0012, 1'b0});
            end
            prev_ready = ready;
        end
        check("b2b_accepts", n_acc, 7);
        check("b2b_done_count", n_done, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
